// File: rtl/cmd_frame_decoder_if.sv
// rtl/cmd_frame_decoder_if.sv - received byte stream in, decoded command and status out
interface cmd_frame_decoder_if #(
  parameter int DATA_SIZE   = 8,
  parameter int NUM_CMDS    = 4,
  parameter int PARAM_BYTES = 2
);
  logic [DATA_SIZE-1:0]             i_rx_data;
  logic                             i_rx_valid;
  logic                             o_wait_cmd;
  logic [NUM_CMDS-1:0]              o_cmd;
  logic                             o_cmd_valid;
  logic [PARAM_BYTES*DATA_SIZE-1:0] o_cmd_param;
  logic                             o_succes;
  logic                             o_error;
  logic [1:0]                       o_err_code;

  // Byte source side (UART receiver / bench)
  modport master (
    output i_rx_data, i_rx_valid,
    input  o_wait_cmd, o_cmd, o_cmd_valid, o_cmd_param, o_succes, o_error, o_err_code
  );

  // Decoder side
  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_wait_cmd, o_cmd, o_cmd_valid, o_cmd_param, o_succes, o_error, o_err_code
  );
endinterface

// File: rtl/cmd_frame_decoder.sv
// rtl/cmd_frame_decoder.sv - framed command decoder (sync, opcode, params, optional checksum via CMD_FRAME_DECODER_CHECKSUM_EN)
module cmd_frame_decoder #(
  parameter int                   DATA_SIZE      = 8,
  parameter int                   NUM_CMDS       = 4,
  parameter int                   PARAM_BYTES    = 2,
  parameter int                   TIMEOUT_CYCLES = 1000000,
  parameter logic [DATA_SIZE-1:0] SYNC_BYTE      = '0
) (
  input logic                i_clock,
  input logic                i_reset_n,
  cmd_frame_decoder_if.slave bus
);
  localparam int PW = PARAM_BYTES * DATA_SIZE;
  localparam int IW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int CW = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam bit                   TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_SIZE-1:0] MAX_OP    = DATA_SIZE'(NUM_CMDS);
  localparam logic [CW-1:0]        LAST_BYTE = CW'(PARAM_BYTES - 1);

`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_PARAM, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_PARAM} state_t;
`endif

  state_t state_q, state_d;

  logic [IW-1:0]        cmd_idx_q;
  logic [PW-1:0]        param_sr_q;
  logic [CW-1:0]        byte_cnt_q;
  logic [TW-1:0]        to_cnt_q;
  logic [NUM_CMDS-1:0]  cmd_q;
  logic                 cmd_valid_q;
  logic [PW-1:0]        param_out_q;
  logic                 error_q;
  logic [1:0]           err_code_q;
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
  logic [DATA_SIZE-1:0] csum_q;
`endif

  logic       op_in_range;
  logic       timeout_hit;
  logic       done;
  logic       fail;
  logic [1:0] fail_code;

  assign op_in_range = (bus.i_rx_data != '0) && (bus.i_rx_data <= MAX_OP);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = TO_EN && !bus.i_rx_valid && (to_cnt_q == TO_LAST);

  // Frame state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state plus the completion / failure decision for this cycle
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    fail      = 1'b0;
    fail_code = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) state_d = S_OPCODE;
      end
      S_OPCODE: begin
        if (bus.i_rx_valid) begin
          if (op_in_range) begin
            state_d = S_PARAM;
          end else begin
            state_d   = S_IDLE;
            fail      = 1'b1;
            fail_code = 2'd1;
          end
        end
      end
      S_PARAM: begin
        if (bus.i_rx_valid && byte_cnt_q == LAST_BYTE) begin
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_IDLE;
          done    = 1'b1;
`endif
        end
      end
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.i_rx_valid) begin
          state_d = S_IDLE;
          if (bus.i_rx_data == csum_q) begin
            done = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd3;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && timeout_hit) begin
      state_d   = S_IDLE;
      fail      = 1'b1;
      fail_code = 2'd2;
    end
  end

  // Frame capture, inter-byte timeout and registered result pulses
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cmd_idx_q   <= '0;
      param_sr_q  <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      param_out_q <= '0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      if (state_q == S_OPCODE && bus.i_rx_valid && op_in_range) begin
        cmd_idx_q  <= IW'(bus.i_rx_data - 1'b1);
        param_sr_q <= '0;
        byte_cnt_q <= '0;
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
        csum_q     <= bus.i_rx_data;
`endif
      end
      if (state_q == S_PARAM && bus.i_rx_valid) begin
        param_sr_q <= (param_sr_q << DATA_SIZE) | PW'(bus.i_rx_data);
        byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
`ifdef CMD_FRAME_DECODER_CHECKSUM_EN
        csum_q     <= csum_q ^ bus.i_rx_data;
`endif
      end

      if (state_q == S_IDLE || state_d == S_IDLE || bus.i_rx_valid) to_cnt_q <= '0;
      else if (to_cnt_q != '1)                                   to_cnt_q <= to_cnt_q + 1'b1;

      cmd_valid_q <= done;
      cmd_q       <= done ? (NUM_CMDS'(1) << cmd_idx_q) : '0;
      error_q     <= fail;
      if (fail) err_code_q <= fail_code;
      // Parameter word is published one edge after the strobe, from the completed shift register.
      if (cmd_valid_q) param_out_q <= param_sr_q;
    end
  end

  assign bus.o_wait_cmd  = (state_q != S_IDLE);
  assign bus.o_cmd       = cmd_q;
  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_succes    = cmd_valid_q;
  assign bus.o_cmd_param = param_out_q;
  assign bus.o_error     = error_q;
  assign bus.o_err_code  = err_code_q;
endmodule

// File: doc/cmd_frame_decoder.md
Name: cmd_frame_decoder

Overview:
- Parametrised successor to the single-byte UART command unit.
- Consumes an already-deserialised byte stream from the UART receiver and decodes framed commands: sync byte, opcode byte, then PARAM_BYTES parameter bytes.
- Emits a one-hot command strobe with a wide parameter word, and reports success or a coded error.
- Adds inter-byte timeout and frame abort; an optional checksum byte is available.

Parameters:
- DATA_SIZE, 8, byte width of the input stream.
- NUM_CMDS, 4, number of commands; width of the one-hot command vector (1..255).
- PARAM_BYTES, 2, parameter bytes per frame (>=1).
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.
- SYNC_BYTE, 8'h00, frame start marker.

Ports:
- i_clock  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_rx_data  in  DATA_SIZE  received byte; valid only while i_rx_valid is high.
- i_rx_valid  in  1  one-cycle strobe per received byte.
- o_wait_cmd  out  1  high while a frame is in progress (any state other than IDLE).
- o_cmd  out  NUM_CMDS  one-hot command; pulses for exactly one cycle together with o_cmd_valid.
- o_cmd_valid  out  1  one-cycle strobe marking a successfully decoded frame.
- o_cmd_param  out  PARAM_BYTES*DATA_SIZE  parameter of the last successful frame; held between frames.
- o_succes  out  1  one-cycle pulse, coincident with o_cmd_valid.
- o_error  out  1  one-cycle pulse on frame failure.
- o_err_code  out  2  cause of the error; held until the next error. 1 = bad opcode, 2 = timeout, 3 = checksum.

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted:
  - state = IDLE;
  - o_cmd = 0, o_cmd_valid = 0, o_succes = 0, o_error = 0;
  - o_cmd_param = 0, o_err_code = 0;
  - byte counter and timeout counter = 0;
  - the partial frame is discarded.
- State machine: IDLE -> OPCODE -> PARAM -> (CHECK) -> IDLE.
- IDLE:
  - valid byte == SYNC_BYTE -> OPCODE.
  - Any other byte is ignored silently; no error is raised.
- OPCODE:
  - valid byte k with 1 <= k <= NUM_CMDS: latch command index k-1 and clear the parameter shift register -> PARAM.
  - k = 0 or k > NUM_CMDS: pulse o_error with code 1 -> IDLE. Parameter bytes that follow are not consumed specially; IDLE ignores them unless they equal SYNC_BYTE.
- PARAM:
  - Each valid byte shifts in MSB-first: the first parameter byte lands in the top byte of the word.
  - The byte counter increments per byte and wraps to 0 after PARAM_BYTES bytes.
  - After the final byte: go to CHECK if the checksum option is enabled; otherwise complete the frame.
- Completion, with the final byte accepted on edge t:
  - o_cmd[index], o_cmd_valid and o_succes are high during cycle t+1 only.
  - o_cmd_param updates on edge t+1 and holds until the next successful frame.
  - State is IDLE in cycle t+1, so a SYNC_BYTE arriving in cycle t+1 starts a new frame.
- Failed frames never change o_cmd_param or o_cmd.
- Timeout:
  - The counter clears on every accepted byte and on entry to IDLE, and counts in the OPCODE, PARAM and CHECK states.
  - When the counter reaches TIMEOUT_CYCLES-1 with no valid byte: pulse o_error with code 2 -> IDLE.
  - If i_rx_valid coincides with expiry, the byte wins and no timeout occurs.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- Only one of o_succes and o_error may be high in any cycle.
- i_rx_valid for consecutive cycles is legal; every strobe is one byte.

Optional Feature:
- Macro: CMD_FRAME_DECODER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the parameters, in state CHECK.
  - Expected value: XOR of the opcode and all parameter bytes.
  - Match -> completion as above, with timing measured from the checksum byte.
  - Mismatch -> o_error with code 3 -> IDLE.
- Undefined:
  - CHECK state and checksum logic are absent.
  - Completion follows the last parameter byte.
  - Code 3 is never produced.

Test Plan (defaults: NUM_CMDS=4, PARAM_BYTES=2, TIMEOUT_CYCLES=1000, SYNC_BYTE=0x00):
- Bytes 00,02,12,34 (checksum off) -> one-cycle o_cmd=4'b0010, o_cmd_valid=1, o_succes=1 on the cycle after 0x34; o_cmd_param=16'h1234 held afterwards; o_wait_cmd high from the cycle after 0x00 through the cycle of 0x34.
- Bytes 00,07 -> o_error pulse with o_err_code=1, state IDLE; o_cmd_param unchanged; a following 00,01,AB,CD decodes as o_cmd=4'b0001, param 16'hABCD.
- Bytes 00,03,55, then silence -> o_error with code 2 exactly 1000 cycles after 0x55; o_wait_cmd drops. A byte arriving on the 1000th cycle instead is accepted and no error occurs.
- Stray bytes 41,FF in IDLE -> no outputs asserted. Back-to-back frame 00,04,00,01 followed by 00,01,FF,FF on consecutive valid cycles -> two o_cmd_valid pulses, with params 16'h0001 then 16'hFFFF.
- Reset (i_reset_n low asynchronously) after bytes 00,02,12 -> all outputs 0 immediately; after release, 34 alone produces nothing.
- With CMD_FRAME_DECODER_CHECKSUM_EN: 00,02,12,34,24 -> success, o_cmd=4'b0010. Then 00,02,12,34,25 -> o_error with code 3, and o_cmd_param stays 16'h1234.
